// File: rtl/prog_launcher.sv
// Loads a program image into data memory, launches the core, then streams back a result window.
// Latency: one write per accepted load byte, one-cycle req, readback one byte per two cycles minimum.
// Backpressure: ld_valid low stalls LOAD; rb_ready low holds rb_data/rb_valid; optional WAIT watchdog via LAUNCH_TIMEOUT_EN.
module prog_launcher #(
  parameter int         LOAD_LEN  = 8,
  parameter logic [7:0] READ_BASE = 8'h40,
  parameter int         READ_LEN  = 4,
  parameter int         TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       mem_wr_en,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wr_dat,
  input  logic [7:0] mem_rd_dat,
  output logic       req,
  input  logic       done,
  output logic       rb_valid,
  output logic [7:0] rb_data,
  input  logic       rb_ready,
  output logic       busy,
  output logic       finished,
  output logic       timed_out
);

  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, RD_ADDR, RD_OUT, FINISH} state_t;

  // Nine-bit index so a length of 256 still reaches its last value.
  localparam logic [8:0] LOAD_LAST = 9'(LOAD_LEN - 1);
  localparam logic [8:0] READ_LAST = 9'(READ_LEN - 1);

  state_t     state, state_nxt;
  logic [8:0] idx, idx_nxt;
  logic [7:0] rb_q, rb_nxt;
  logic       wait_first, wait_first_nxt;

`ifdef LAUNCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          tout_q;

  // Count WAIT cycles, restarting from zero on every entry into WAIT.
  always_ff @(posedge clk) begin
    if (reset)                wait_cnt <= '0;
    else if (state == LAUNCH) wait_cnt <= '0;
    else if (state == WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky watchdog flag: cleared by a new start, set when WAIT expires.
  always_ff @(posedge clk) begin
    if (reset)                      tout_q <= 1'b0;
    else if (state == IDLE && start) tout_q <= 1'b0;
    else if (timeout_hit)            tout_q <= 1'b1;
  end

  assign timed_out = reset ? 1'b0 : tout_q;
`else
  assign timed_out = 1'b0;
`endif

  // State, index, capture register and stale-done guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      rb_q       <= '0;
      wait_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rb_q       <= rb_nxt;
      wait_first <= wait_first_nxt;
    end
  end

  assign rb_data = reset ? 8'h00 : rb_q;

  // Next-state and output decode; reset forces every output low in its own cycle.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    rb_nxt         = rb_q;
    wait_first_nxt = 1'b0;
    busy           = 1'b0;
    ld_ready       = 1'b0;
    mem_wr_en      = 1'b0;
    mem_addr       = 8'h00;
    mem_wr_dat     = 8'h00;
    req            = 1'b0;
    rb_valid       = 1'b0;
    finished       = 1'b0;
`ifdef LAUNCH_TIMEOUT_EN
    timeout_hit    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        ld_ready = 1'b1;
        mem_addr = idx[7:0];
        if (ld_valid) begin
          mem_wr_en  = 1'b1;
          mem_wr_dat = ld_data;
          idx_nxt    = idx + 9'd1;
          if (idx == LOAD_LAST) state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        busy           = 1'b1;
        req            = 1'b1;
        wait_first_nxt = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        // A done left high from a previous run must not end this one.
        if (!wait_first && done) begin
          state_nxt = RD_ADDR;
          idx_nxt   = '0;
        end
`ifdef LAUNCH_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = FINISH;
          timeout_hit = 1'b1;
        end
`endif
      end
      RD_ADDR: begin
        busy      = 1'b1;
        mem_addr  = READ_BASE + idx[7:0];
        rb_nxt    = mem_rd_dat;
        state_nxt = RD_OUT;
      end
      RD_OUT: begin
        busy     = 1'b1;
        rb_valid = 1'b1;
        if (rb_ready) begin
          if (idx == READ_LAST) begin
            state_nxt = FINISH;
          end else begin
            idx_nxt   = idx + 9'd1;
            state_nxt = RD_ADDR;
          end
        end
      end
      FINISH: begin
        busy      = 1'b1;
        finished  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      busy       = 1'b0;
      ld_ready   = 1'b0;
      mem_wr_en  = 1'b0;
      mem_addr   = 8'h00;
      mem_wr_dat = 8'h00;
      req        = 1'b0;
      rb_valid   = 1'b0;
      finished   = 1'b0;
    end
  end

endmodule
